// File: rtl/lut_wave_gen_if.sv
// rtl/lut_wave_gen_if.sv - sample-set output stream between lut_wave_gen and its consumer
interface lut_wave_gen_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 2
) ();
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/lut_wave_gen.sv
// rtl/lut_wave_gen.sv - NUM_CH phase-offset waveform streams from one shared writable sample table
// Optional LUT_WAVE_GEN_GAIN_EN: per-run gain multiply with one extra output pipeline stage.
module lut_wave_gen #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int FRAC_W = 4,
  parameter int NUM_CH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [ADDR_W+FRAC_W-1:0] step,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
`ifdef LUT_WAVE_GEN_GAIN_EN
  input  logic [7:0]               gain,
`endif
  lut_wave_gen_if.master           ob,
  output logic                     wrap,
  output logic                     busy
);
  localparam int PHASE_W = ADDR_W + FRAC_W;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int QUARTER = DEPTH / 4;
  localparam logic [127:0] DEF16 = {8'd35, 8'd50, 8'd73, 8'd100, 8'd127, 8'd150, 8'd165, 8'd171,
                                    8'd165, 8'd150, 8'd127, 8'd100, 8'd73, 8'd50, 8'd35, 8'd29};

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  typedef logic [DATA_W-1:0] tbl_t [DEPTH];

  function automatic tbl_t init_tbl();
    tbl_t t;
    for (int i = 0; i < DEPTH; i++) begin
      t[i] = (DEPTH == 16) ? DATA_W'(DEF16[(i % 16) * 8 +: 8]) : '0;
    end
    return t;
  endfunction

  // Table keeps its power-up contents across rst; only IDLE writes change it.
  tbl_t tbl_q = init_tbl();

  state_t                   state_q, state_d;
  logic [PHASE_W-1:0]       phase_q, phase_d, step_q, step_d;
  logic [NUM_CH*DATA_W-1:0] data_q, data_d, lut_set;
  logic                     valid_q, valid_d, wrap_q, wrap_d;
  logic [ADDR_W-1:0]        idx;
  logic [PHASE_W:0]         sum;
  logic                     advance, tbl_we;
`ifdef LUT_WAVE_GEN_GAIN_EN
  logic [7:0]               gain_q, gain_d;
  logic [NUM_CH*DATA_W-1:0] s1_q, s1_d, scaled;
  logic                     s1_valid_q, s1_valid_d;
  logic [DATA_W+7:0]        prod;
`endif

  always_comb begin
    lut_set = '0;
    idx     = phase_q[PHASE_W-1:FRAC_W];
    for (int c = 0; c < NUM_CH; c++) begin
      lut_set[c*DATA_W +: DATA_W] = tbl_q[idx + ADDR_W'(c * QUARTER)];
    end
  end

`ifdef LUT_WAVE_GEN_GAIN_EN
  always_comb begin
    scaled = '0;
    prod   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      prod = s1_q[c*DATA_W +: DATA_W] * gain_q;
      scaled[c*DATA_W +: DATA_W] = prod[DATA_W+7:8];
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (stop) state_d = IDLE;
               else if (valid_q && !ob.out_ready) state_d = HOLD;
      HOLD:    if (stop) state_d = IDLE;
               else if (ob.out_ready) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // The whole pipeline moves as one: nothing advances while the output set is unaccepted.
  always_comb begin
    phase_d = phase_q;
    step_d  = step_q;
    data_d  = data_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    tbl_we  = wr_en && (state_q == IDLE) && !rst;
    sum     = {1'b0, phase_q} + {1'b0, step_q};
    advance = (state_q != IDLE) && !stop && (!valid_q || ob.out_ready);
`ifdef LUT_WAVE_GEN_GAIN_EN
    gain_d     = gain_q;
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
`endif
    if (state_q == IDLE && start) begin
      step_d  = step;
      phase_d = '0;
`ifdef LUT_WAVE_GEN_GAIN_EN
      gain_d  = gain;
`endif
    end
    if (state_q != IDLE && stop) begin
      valid_d = 1'b0;
`ifdef LUT_WAVE_GEN_GAIN_EN
      s1_valid_d = 1'b0;
`endif
    end
    if (advance) begin
      phase_d = sum[PHASE_W-1:0];
      wrap_d  = sum[PHASE_W];
`ifdef LUT_WAVE_GEN_GAIN_EN
      s1_d       = lut_set;
      s1_valid_d = 1'b1;
      data_d     = scaled;
      valid_d    = s1_valid_q;
`else
      data_d  = lut_set;
      valid_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      step_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
`ifdef LUT_WAVE_GEN_GAIN_EN
      gain_q     <= '0;
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
`ifdef LUT_WAVE_GEN_GAIN_EN
      gain_q     <= gain_d;
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) tbl_q[wr_addr] <= wr_data;
  end

  assign ob.out_data  = data_q;
  assign ob.out_valid = valid_q;
  assign wrap         = wrap_q;
  assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_lut_wave_gen.sv
// tb/tb_lut_wave_gen.sv - directed scoreboard bench for lut_wave_gen
module tb_lut_wave_gen;
  logic       clk = 1'b0;
  logic       rst, start, stop, wr_en;
  logic [7:0] step, wr_data;
  logic [3:0] wr_addr;
  logic       wrap, busy;
`ifdef LUT_WAVE_GEN_GAIN_EN
  logic [7:0] gain = 8'h80;
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0]  mtbl [16] = '{8'd29, 8'd35, 8'd50, 8'd73, 8'd100, 8'd127, 8'd150, 8'd165,
                             8'd171, 8'd165, 8'd150, 8'd127, 8'd100, 8'd73, 8'd50, 8'd35};
  logic [15:0] exp_q [$];

  lut_wave_gen_if #(.DATA_W(8), .NUM_CH(2)) wave_if ();

  lut_wave_gen dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .step    (step),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
`ifdef LUT_WAVE_GEN_GAIN_EN
    .gain    (gain),
`endif
    .ob      (wave_if),
    .wrap    (wrap),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] scale(input logic [7:0] v);
`ifdef LUT_WAVE_GEN_GAIN_EN
    logic [15:0] p;
    p = v * gain;
    return p[15:8];
`else
    return v;
`endif
  endfunction

  function automatic logic [15:0] exp_set(input logic [7:0] ph);
    logic [3:0] i0, i1;
    i0 = ph[7:4];
    i1 = i0 + 4'd4;
    return {scale(mtbl[i1]), scale(mtbl[i0])};
  endfunction

  task automatic run_stream(input logic [7:0] stp, input int n, input int stall_at,
                            input int stall_len, input bit wr_mid, input string tag);
    logic [7:0] ph;
    int got, cyc, stalled, wraps, first_cyc;
    ph = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_set(ph));
      ph = ph + stp;
    end
    @(negedge clk);
    start = 1'b1;
    step = stp;
    wave_if.out_ready = 1'b1;
    got = 0; cyc = 0; stalled = 0; wraps = 0; first_cyc = -1;
    while (got < n && cyc < 400) begin
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      cyc++;
      if (wrap) wraps++;
      if (wave_if.out_valid && first_cyc < 0) first_cyc = cyc;
      if (wr_mid && cyc == 3) begin
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'h55;
      end
      if (got == stall_at && stalled < stall_len && wave_if.out_valid) begin
        wave_if.out_ready = 1'b0;
        stalled++;
        check({tag, " hold data"}, wave_if.out_data, exp_q[0]);
        check({tag, " hold busy"}, busy, 1);
      end else begin
        wave_if.out_ready = 1'b1;
      end
      if (wave_if.out_valid && wave_if.out_ready) begin
        check({tag, " data"}, wave_if.out_data, exp_q.pop_front());
        got++;
      end
    end
    check({tag, " sample count"}, got, n);
    check({tag, " first valid"}, first_cyc, LAT);
    @(negedge clk);
    wr_en = 1'b0;
    if (wrap) wraps++;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check({tag, " stop valid"}, wave_if.out_valid, 0);
    check({tag, " stop busy"}, busy, 0);
    check({tag, " stop wrap"}, wrap, 0);
    check({tag, " wraps"}, wraps, ((n + LAT - 1) * int'(stp)) / 256);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; step = 8'h00;
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'h00;
    wave_if.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset valid", wave_if.out_valid, 0);
    check("reset data", wave_if.out_data, 0);
    check("reset busy", busy, 0);
    check("reset wrap", wrap, 0);
    rst = 1'b0;

    run_stream(8'h10, 34, -1, 0, 1'b0, "step10");
    run_stream(8'h08, 40, 10, 3, 1'b0, "step08 stall");
    run_stream(8'h00, 5, -1, 0, 1'b0, "step00");
    run_stream(8'hFF, 20, -1, 0, 1'b0, "reverse");

    // Table load in IDLE
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hFF;
    @(negedge clk);
    wr_addr = 4'd8; wr_data = 8'h00;
    @(negedge clk);
    wr_en = 1'b0;
    mtbl[0] = 8'hFF;
    mtbl[8] = 8'h00;
    run_stream(8'h10, 20, -1, 0, 1'b1, "load wrrun");
    run_stream(8'h10, 18, -1, 0, 1'b0, "after wrrun");

    // Stop while stalled in HOLD
    @(negedge clk);
    start = 1'b1; step = 8'h10; wave_if.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (LAT) @(negedge clk);
    check("hold valid", wave_if.out_valid, 1);
    check("hold busy", busy, 1);
    check("hold data", wave_if.out_data, exp_set(8'h00));
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("hold stop valid", wave_if.out_valid, 0);
    check("hold stop busy", busy, 0);
    wave_if.out_ready = 1'b1;

    // Reset mid-run
    @(negedge clk);
    start = 1'b1; step = 8'h10;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst run data", wave_if.out_data, 0);
    check("rst run valid", wave_if.out_valid, 0);
    check("rst run busy", busy, 0);
    check("rst run wrap", wrap, 0);
    run_stream(8'h10, 17, -1, 0, 1'b0, "after rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
